// File: rtl/sccb_pkg.sv
// rtl/sccb_pkg.sv - shared states and constants for the SCCB master
package sccb_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        TX_BYTE,
        ACK_RX,
        RX_BYTE,
        NACK_TX,
        STOP,
        DONE
    } sccb_state_e;

    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;

    localparam logic SCCB_WR = 1'b0;
    localparam logic SCCB_RD = 1'b1;

endpackage

// File: rtl/sccb_bit_timer.sv
// rtl/sccb_bit_timer.sv - quarter-bit prescaler and quarter counter for one SCCB bit slot
module sccb_bit_timer
    import sccb_pkg::*;
#(
    parameter int QTR_DIV = 1
) (
    input  logic       clk_80K,
    input  logic       rst_n,
    input  logic       clr,
    output logic [1:0] qtr,
    output logic       qtr_last,
    output logic       slot_end
);

    localparam int PW = (QTR_DIV > 1) ? $clog2(QTR_DIV) : 1;

    logic [PW-1:0] pre_q, pre_d;
    logic [1:0]    qtr_q, qtr_d;

    assign qtr      = qtr_q;
    assign qtr_last = (pre_q == PW'(QTR_DIV - 1));
    assign slot_end = qtr_last && (qtr_q == Q3);

    // Next-state: hold at q0 while cleared, otherwise count cycles then quarters
    always_comb begin
        pre_d = pre_q;
        qtr_d = qtr_q;
        if (clr) begin
            pre_d = '0;
            qtr_d = Q0;
        end else if (qtr_last) begin
            pre_d = '0;
            qtr_d = qtr_q + 2'd1;
        end else begin
            pre_d = pre_q + 1'b1;
        end
    end

    // Prescaler and quarter registers
    always_ff @(posedge clk_80K or negedge rst_n) begin
        if (!rst_n) begin
            pre_q <= '0;
            qtr_q <= Q0;
        end else begin
            pre_q <= pre_d;
            qtr_q <= qtr_d;
        end
    end

endmodule

// File: rtl/sccb_master.sv
// rtl/sccb_master.sv - SCCB/I2C register write/read master for OV5640 configuration
module sccb_master
    import sccb_pkg::*;
#(
    parameter int ADDR_BYTES = 2,
    parameter int QTR_DIV    = 1,
    parameter int CHECK_ACK  = 1
) (
    input  logic                    clk_80K,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    rw,
    input  logic [6:0]              dev_addr,
    input  logic [8*ADDR_BYTES-1:0] reg_addr,
    input  logic [7:0]              wr_data,
    output logic [7:0]              rd_data,
    output logic                    busy,
    output logic                    done,
    output logic                    ack_err,
    output logic                    scl,
    output logic                    sda_out,
    output logic                    sda_oe,
    input  logic                    sda_in
);

    sccb_state_e             state_q, state_d;
    logic                    rw_q, rw_d;
    logic [6:0]              dev_q, dev_d;
    logic [8*ADDR_BYTES-1:0] reg_q, reg_d;
    logic [7:0]              wr_q, wr_d;
    logic [7:0]              shreg_q, shreg_d;
    logic [7:0]              rx_q, rx_d;
    logic [7:0]              rd_data_q, rd_data_d;
    logic [3:0]              bit_cnt_q, bit_cnt_d;
    logic [1:0]              byte_cnt_q, byte_cnt_d;
    logic                    phase_q, phase_d;
    logic                    ack_err_q, ack_err_d;

    logic [1:0] qtr;
    logic       qtr_last;
    logic       slot_end;
    logic       sample;
    logic       timer_clr;
    logic       data_scl;
    logic [1:0] nxt_idx;
    logic [1:0] last_byte;
    logic [7:0] tx_next;

    // Timer parked at q0 whenever no slot is in progress
    assign timer_clr = (state_q == IDLE) || (state_q == DONE);

    sccb_bit_timer #(
        .QTR_DIV (QTR_DIV)
    ) u_timer (
        .clk_80K  (clk_80K),
        .rst_n    (rst_n),
        .clr      (timer_clr),
        .qtr      (qtr),
        .qtr_last (qtr_last),
        .slot_end (slot_end)
    );

    assign sample    = qtr_last && (qtr == Q2);
    assign data_scl  = (qtr == Q1) || (qtr == Q2);
    assign nxt_idx   = byte_cnt_q + 2'd1;
    // A read's first phase stops after the register address; a write also sends data
    assign last_byte = (rw_q == SCCB_RD) ? 2'(ADDR_BYTES) : 2'(ADDR_BYTES + 1);

    assign busy    = (state_q != IDLE);
    assign done    = (state_q == DONE);
    assign ack_err = ack_err_q;
    assign rd_data = rd_data_q;

    // Select the next byte to shift out: register address MSB byte first, then write data
    always_comb begin
        tx_next = wr_q;
        for (int k = 1; k <= ADDR_BYTES; k++) begin
            if (nxt_idx == 2'(k)) tx_next = reg_q[8*(ADDR_BYTES-k) +: 8];
        end
    end

    // FSM next-state, shift register and counters
    always_comb begin
        state_d    = state_q;
        rw_d       = rw_q;
        dev_d      = dev_q;
        reg_d      = reg_q;
        wr_d       = wr_q;
        shreg_d    = shreg_q;
        rx_d       = rx_q;
        rd_data_d  = rd_data_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        phase_d    = phase_q;
        ack_err_d  = ack_err_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    rw_d      = rw;
                    dev_d     = dev_addr;
                    reg_d     = reg_addr;
                    wr_d      = wr_data;
                    ack_err_d = 1'b0;
                    phase_d   = 1'b0;
                    state_d   = START;
                end
            end
            START: begin
                if (slot_end) begin
                    shreg_d    = {dev_q, phase_q};
                    bit_cnt_d  = 4'd0;
                    byte_cnt_d = 2'd0;
                    state_d    = TX_BYTE;
                end
            end
            TX_BYTE: begin
                if (slot_end) begin
                    shreg_d = {shreg_q[6:0], 1'b0};
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = 4'd0;
                        state_d   = ACK_RX;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ACK_RX: begin
                if (sample && (CHECK_ACK != 0) && sda_in) ack_err_d = 1'b1;
                if (slot_end) begin
                    if (ack_err_q) begin
                        state_d = STOP;
                    end else if (phase_q) begin
                        bit_cnt_d = 4'd0;
                        state_d   = RX_BYTE;
                    end else if (byte_cnt_q == last_byte) begin
                        state_d = STOP;
                    end else begin
                        byte_cnt_d = nxt_idx;
                        shreg_d    = tx_next;
                        state_d    = TX_BYTE;
                    end
                end
            end
            RX_BYTE: begin
                if (sample) rx_d = {rx_q[6:0], sda_in};
                if (slot_end) begin
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = 4'd0;
                        state_d   = NACK_TX;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            NACK_TX: begin
                if (slot_end) state_d = STOP;
            end
            STOP: begin
                if (slot_end) begin
                    if ((rw_q == SCCB_RD) && !phase_q && !ack_err_q) begin
                        phase_d = 1'b1;
                        state_d = START;
                    end else begin
                        if ((rw_q == SCCB_RD) && !ack_err_q) rd_data_d = rx_q;
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Bus pin decode from state and quarter; idle bus is SCL high, SDA released
    always_comb begin
        scl     = 1'b1;
        sda_out = 1'b1;
        sda_oe  = 1'b0;
        case (state_q)
            START: begin
                sda_oe  = 1'b1;
                sda_out = (qtr == Q0) || (qtr == Q1);
                scl     = (qtr != Q3);
            end
            TX_BYTE: begin
                sda_oe  = 1'b1;
                sda_out = shreg_q[7];
                scl     = data_scl;
            end
            ACK_RX, RX_BYTE: begin
                scl = data_scl;
            end
            NACK_TX: begin
                sda_oe = 1'b1;
                scl    = data_scl;
            end
            STOP: begin
                sda_oe  = 1'b1;
                sda_out = (qtr == Q2) || (qtr == Q3);
                scl     = (qtr != Q0);
            end
            default: begin
            end
        endcase
    end

    // State and datapath registers; reset releases the bus at once
    always_ff @(posedge clk_80K or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rw_q       <= SCCB_WR;
            dev_q      <= '0;
            reg_q      <= '0;
            wr_q       <= '0;
            shreg_q    <= '0;
            rx_q       <= '0;
            rd_data_q  <= '0;
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            phase_q    <= 1'b0;
            ack_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rw_q       <= rw_d;
            dev_q      <= dev_d;
            reg_q      <= reg_d;
            wr_q       <= wr_d;
            shreg_q    <= shreg_d;
            rx_q       <= rx_d;
            rd_data_q  <= rd_data_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            phase_q    <= phase_d;
            ack_err_q  <= ack_err_d;
        end
    end

endmodule

// File: tb/tb_sccb_master.sv
// tb/tb_sccb_master.sv - directed self-checking bench for sccb_master
module tb_sccb_master;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start0, start1;
    logic        rw;
    logic [6:0]  dev_addr;
    logic [15:0] reg_addr;
    logic [7:0]  wr_data;

    logic [7:0] rd_data0, rd_data1;
    logic busy0, done0, ack_err0, scl0, sda_out0, sda_oe0, sda_in0;
    logic busy1, done1, ack_err1, scl1, sda_out1, sda_oe1, sda_in1;

    int         sel       = 0;
    logic       slv       = 1'b1;
    logic       no_slave  = 1'b0;
    int         nack_byte = -1;
    logic [7:0] rd_val    = 8'h00;

    logic mon_scl, mon_sda;

    assign sda_in0 = (sda_oe0 ? sda_out0 : 1'b1) & ((sel == 0) ? slv : 1'b1);
    assign sda_in1 = (sda_oe1 ? sda_out1 : 1'b1) & ((sel == 1) ? slv : 1'b1);
    assign mon_scl = (sel == 1) ? scl1 : scl0;
    assign mon_sda = (sel == 1) ? sda_in1 : sda_in0;

    sccb_master #(.ADDR_BYTES(2), .QTR_DIV(1), .CHECK_ACK(1)) u0 (
        .clk_80K(clk), .rst_n(rst_n), .start(start0), .rw(rw), .dev_addr(dev_addr),
        .reg_addr(reg_addr), .wr_data(wr_data), .rd_data(rd_data0), .busy(busy0),
        .done(done0), .ack_err(ack_err0), .scl(scl0), .sda_out(sda_out0),
        .sda_oe(sda_oe0), .sda_in(sda_in0)
    );

    sccb_master #(.ADDR_BYTES(1), .QTR_DIV(3), .CHECK_ACK(0)) u1 (
        .clk_80K(clk), .rst_n(rst_n), .start(start1), .rw(rw), .dev_addr(dev_addr),
        .reg_addr(reg_addr[7:0]), .wr_data(wr_data), .rd_data(rd_data1), .busy(busy1),
        .done(done1), .ack_err(ack_err1), .scl(scl1), .sda_out(sda_out1),
        .sda_oe(sda_oe1), .sda_in(sda_in1)
    );

    // Bus monitor and slave model
    int         bit_idx = 0;
    int         byte_no = 0;
    logic       active  = 1'b0;
    logic       rd_mode = 1'b0;
    logic       prev_c  = 1'b1;
    logic       prev_s  = 1'b1;
    logic [7:0] cur     = 8'h00;
    logic [7:0] byte_q[$];
    logic       ack_q[$];
    int         n_start = 0;
    int         n_stop  = 0;
    int         n_viol  = 0;

    always begin
        @(posedge clk);
        #1;
        if (prev_c && mon_scl && (mon_sda != prev_s)) begin
            if (!mon_sda) begin
                n_start++;
                active  = 1'b1;
                bit_idx = -1;
                byte_no = 0;
                rd_mode = 1'b0;
            end else begin
                n_stop++;
                active = 1'b0;
            end
        end else if ((prev_c != mon_scl) && (mon_sda != prev_s)) begin
            n_viol++;
        end
        if (active && !prev_c && mon_scl) begin
            if (bit_idx >= 0 && bit_idx < 8) cur = {cur[6:0], mon_sda};
            if (bit_idx == 7) begin
                byte_q.push_back(cur);
                if (byte_no == 0) rd_mode = cur[0];
            end
            if (bit_idx == 8) ack_q.push_back(mon_sda);
        end
        if (active && prev_c && !mon_scl) begin
            bit_idx++;
            if (bit_idx == 9) begin
                bit_idx = 0;
                byte_no++;
            end
            slv = 1'b1;
            if (!no_slave) begin
                if (rd_mode && byte_no == 1) begin
                    if (bit_idx < 8) slv = rd_val[7-bit_idx];
                end else if (bit_idx == 8) begin
                    slv = (byte_no == nack_byte) ? 1'b1 : 1'b0;
                end
            end
        end
        if (!active) slv = 1'b1;
        prev_c = mon_scl;
        prev_s = mon_sda;
    end

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    logic [7:0] exp_b[$];
    logic       exp_a[$];
    int b_byte, b_ack, b_st, b_sp, b_vi;

    task automatic snap();
        b_byte = byte_q.size();
        b_ack  = ack_q.size();
        b_st   = n_start;
        b_sp   = n_stop;
        b_vi   = n_viol;
    endtask

    task automatic check_bus(input string tag, input int st, input int sp);
        logic [31:0] g;
        check({tag, "_nbytes"}, byte_q.size() - b_byte, exp_b.size());
        for (int i = 0; i < exp_b.size(); i++) begin
            g = (b_byte + i < byte_q.size()) ? 32'(byte_q[b_byte+i]) : 32'hDEAD;
            check($sformatf("%s_byte%0d", tag, i), g, exp_b[i]);
        end
        check({tag, "_nacks"}, ack_q.size() - b_ack, exp_a.size());
        for (int i = 0; i < exp_a.size(); i++) begin
            g = (b_ack + i < ack_q.size()) ? 32'(ack_q[b_ack+i]) : 32'hDEAD;
            check($sformatf("%s_ack%0d", tag, i), g, exp_a[i]);
        end
        check({tag, "_starts"}, n_start - b_st, st);
        check({tag, "_stops"}, n_stop - b_sp, sp);
        check({tag, "_sda_vs_scl"}, n_viol - b_vi, 0);
    endtask

    task automatic run_txn(input int which, input logic rw_v, input logic [15:0] reg_v,
                           input logic [7:0] wd_v, input int pulse_at, output int ncyc,
                           output logic [7:0] rd_at, output logic err_at);
        int   n;
        logic got;
        @(negedge clk);
        rw       = rw_v;
        dev_addr = 7'h3C;
        reg_addr = reg_v;
        wr_data  = wd_v;
        if (which == 0) start0 = 1'b1;
        else start1 = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        start1 = 1'b0;
        check("busy_after_accept", (which == 0) ? busy0 : busy1, 1);
        check("ack_err_cleared", (which == 0) ? ack_err0 : ack_err1, 0);
        n   = 0;
        got = 1'b0;
        rd_at  = 8'h00;
        err_at = 1'b0;
        while (n < 3000 && !got) begin
            @(posedge clk);
            #1;
            n++;
            if (n == pulse_at) begin
                rw       = 1'b1;
                dev_addr = 7'h21;
                reg_addr = 16'hFFFF;
                wr_data  = 8'hFF;
                if (which == 0) start0 = 1'b1;
                else start1 = 1'b1;
            end else begin
                start0 = 1'b0;
                start1 = 1'b0;
            end
            if ((which == 0) ? done0 : done1) begin
                got    = 1'b1;
                rd_at  = (which == 0) ? rd_data0 : rd_data1;
                err_at = (which == 0) ? ack_err0 : ack_err1;
                check("busy_with_done", (which == 0) ? busy0 : busy1, 1);
            end
        end
        ncyc = got ? n : -1;
        @(posedge clk);
        #1;
        check("done_one_cycle", (which == 0) ? done0 : done1, 0);
        check("busy_falls", (which == 0) ? busy0 : busy1, 0);
    endtask

    initial begin
        int         nc;
        logic [7:0] rdv;
        logic       errv;

        rst_n    = 1'b0;
        start0   = 1'b0;
        start1   = 1'b0;
        rw       = 1'b0;
        dev_addr = 7'h00;
        reg_addr = 16'h0000;
        wr_data  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_scl", scl0, 1);
        check("rst_sda_out", sda_out0, 1);
        check("rst_sda_oe", sda_oe0, 0);
        check("rst_busy", busy0, 0);
        check("rst_done", done0, 0);
        check("rst_ack_err", ack_err0, 0);
        check("rst_rd_data", rd_data0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Register write 3C / 3008 / 82, slave ACKs everything
        snap();
        run_txn(0, 1'b0, 16'h3008, 8'h82, -1, nc, rdv, errv);
        check("wr_cycles", nc, 152);
        check("wr_ack_err", errv, 0);
        exp_b = '{8'h78, 8'h30, 8'h08, 8'h82};
        exp_a = '{1'b0, 1'b0, 1'b0, 1'b0};
        check_bus("wr", 1, 1);

        // Two-phase read of 300A, slave returns 56
        rd_val = 8'h56;
        snap();
        run_txn(0, 1'b1, 16'h300A, 8'h00, -1, nc, rdv, errv);
        check("rd_cycles", nc, 196);
        check("rd_data_at_done", rdv, 8'h56);
        check("rd_ack_err", errv, 0);
        exp_b = '{8'h78, 8'h30, 8'h0A, 8'h79, 8'h56};
        exp_a = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        check_bus("rd", 2, 2);

        // Slave NACKs the second byte: abort straight to STOP
        nack_byte = 1;
        snap();
        run_txn(0, 1'b0, 16'h3008, 8'h82, -1, nc, rdv, errv);
        check("nack_cycles", nc, 80);
        check("nack_ack_err", errv, 1);
        check("nack_ack_err_sticky", ack_err0, 1);
        check("nack_rd_data_hold", rd_data0, 8'h56);
        exp_b = '{8'h78, 8'h30};
        exp_a = '{1'b0, 1'b1};
        check_bus("nack", 1, 1);
        nack_byte = -1;

        // Normal write clears ack_err; a start pulse mid-transfer is ignored
        snap();
        run_txn(0, 1'b0, 16'h3100, 8'h11, 20, nc, rdv, errv);
        check("busy_start_cycles", nc, 152);
        check("busy_start_ack_err", errv, 0);
        exp_b = '{8'h78, 8'h31, 8'h00, 8'h11};
        exp_a = '{1'b0, 1'b0, 1'b0, 1'b0};
        check_bus("ignored", 1, 1);
        repeat (4) @(posedge clk);
        #1;
        check("no_restart_busy", busy0, 0);

        // One address byte, quarter = 3 cycles, ACK ignored, no slave present
        sel      = 1;
        no_slave = 1'b1;
        snap();
        run_txn(1, 1'b0, 16'h0012, 8'hA5, -1, nc, rdv, errv);
        check("ab1_cycles", nc, 348);
        check("ab1_ack_err", errv, 0);
        exp_b = '{8'h78, 8'h12, 8'hA5};
        exp_a = '{1'b1, 1'b1, 1'b1};
        check_bus("ab1", 1, 1);
        sel      = 0;
        no_slave = 1'b0;

        // Asynchronous reset in the middle of a write
        @(negedge clk);
        rw       = 1'b0;
        dev_addr = 7'h3C;
        reg_addr = 16'h3008;
        wr_data  = 8'h82;
        start0   = 1'b1;
        @(posedge clk);
        #1;
        start0 = 1'b0;
        repeat (60) begin
            @(posedge clk);
            #1;
        end
        check("pre_reset_busy", busy0, 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("async_rst_scl", scl0, 1);
        check("async_rst_sda_oe", sda_oe0, 0);
        check("async_rst_busy", busy0, 0);
        check("async_rst_done", done0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_idle", busy0, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
